// File: rtl/cpu_alu_seq_pkg.sv
// Opcode map and shared types for the sequential CPU ALU.
// Legacy 4-bit codes keep bit 4 clear; extended codes set it.
package cpu_alu_seq_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD         = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB         = 5'h01;
  localparam logic [OP_W-1:0] OP_AND         = 5'h02;
  localparam logic [OP_W-1:0] OP_OR          = 5'h03;
  localparam logic [OP_W-1:0] OP_XOR         = 5'h04;
  localparam logic [OP_W-1:0] OP_PASS_A      = 5'h05;
  localparam logic [OP_W-1:0] OP_PASS_B      = 5'h06;
  localparam logic [OP_W-1:0] OP_MOVE_REG_XA = 5'h07;
  localparam logic [OP_W-1:0] OP_MOVE_REG_AX = 5'h08;
  localparam logic [OP_W-1:0] OP_SHL         = 5'h09;
  localparam logic [OP_W-1:0] OP_SHR         = 5'h0A;
  localparam logic [OP_W-1:0] OP_INC         = 5'h0B;
  localparam logic [OP_W-1:0] OP_DEC         = 5'h0C;

  localparam logic [OP_W-1:0] OP_ADC         = 5'h10;
  localparam logic [OP_W-1:0] OP_SBC         = 5'h11;
  localparam logic [OP_W-1:0] OP_MUL         = 5'h12;
  localparam logic [OP_W-1:0] OP_DIVU        = 5'h13;
  localparam logic [OP_W-1:0] OP_MODU        = 5'h14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_multi(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_MODU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/cpu_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH register.
// Mul: acc = {product_hi, multiplier/product_lo}; div: acc = {remainder, dividend/quotient}.
module cpu_alu_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] hi_c,
  output logic             high_nz_c,
  output logic             div_zero
);

  localparam int unsigned AW = 2 * WIDTH;

  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [WIDTH-1:0] divisor;
  logic             mode_div;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One iteration; lo_c/hi_c expose the post-step value so the final step can be retired directly.
  always_comb begin
    sum      = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    shifted  = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (mode_div) begin
      if (shifted >= {1'b0, divisor}) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign lo_c      = acc_next[WIDTH-1:0];
  assign hi_c      = acc_next[AW-1:WIDTH];
  assign high_nz_c = |acc_next[AW-1:WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc      <= '0;
      divisor  <= '0;
      mode_div <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      acc      <= {WIDTH'(0), a};
      divisor  <= b;
      mode_div <= div;
      div_zero <= div && (b == '0);
    end else if (step) begin
      acc      <= acc_next;
    end
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle legacy ops, ADC/SBC,
// and iterative MUL/DIVU/MODU through cpu_alu_muldiv.
module cpu_alu_seq
  import cpu_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic             z_o,
  output logic             c_o,
  output logic             v_o,
  output logic             n_o
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned XW  = WIDTH + 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] a_q;

  logic             md_load;
  logic             md_step;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             md_high_nz;
  logic             md_div_zero;

  logic             cin;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   dif_x;
  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_v;

  assign md_load = (state == S_IDLE) && start_i && is_multi(op_i);
  assign md_step = (state == S_ITER);

  cpu_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (md_load),
    .step      (md_step),
    .div       (is_div(op_i)),
    .a         (a_i),
    .b         (b_i),
    .lo_c      (md_lo),
    .hi_c      (md_hi),
    .high_nz_c (md_high_nz),
    .div_zero  (md_div_zero)
  );

  // Result selection: live operands in IDLE, iterative unit on its final ITER step.
  always_comb begin
    cin   = ((op_i == OP_ADC) || (op_i == OP_SBC)) ? c_o : 1'b0;
    sum_x = {1'b0, a_i} + {1'b0, b_i} + XW'(cin);
    dif_x = {1'b0, a_i} - {1'b0, b_i} - XW'(cin);
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (state == S_ITER) begin
      case (op_q)
        OP_MUL: begin
          res_y = md_lo;
          res_c = md_high_nz;
        end
        OP_DIVU: begin
          res_y = md_div_zero ? '1 : md_lo;
          res_c = md_div_zero;
        end
        OP_MODU: begin
          res_y = md_div_zero ? a_q : md_hi;
          res_c = md_div_zero;
        end
        default: ;
      endcase
    end else begin
      case (op_i)
        OP_ADD, OP_ADC: begin
          res_y = sum_x[WIDTH-1:0];
          res_c = sum_x[WIDTH];
          res_v = (a_i[MSB] == b_i[MSB]) && (sum_x[MSB] != a_i[MSB]);
        end
        OP_SUB, OP_SBC: begin
          res_y = dif_x[WIDTH-1:0];
          res_c = dif_x[WIDTH];
          res_v = (a_i[MSB] != b_i[MSB]) && (dif_x[MSB] != a_i[MSB]);
        end
        OP_AND:                    res_y = a_i & b_i;
        OP_OR:                     res_y = a_i | b_i;
        OP_XOR:                    res_y = a_i ^ b_i;
        OP_PASS_A, OP_MOVE_REG_XA: res_y = a_i;
        OP_PASS_B, OP_MOVE_REG_AX: res_y = b_i;
        OP_SHL: begin
          res_y = {a_i[WIDTH-2:0], 1'b0};
          res_c = a_i[MSB];
        end
        OP_SHR: begin
          res_y = {1'b0, a_i[WIDTH-1:1]};
          res_c = a_i[0];
        end
        OP_INC: begin
          res_y = a_i + WIDTH'(1);
          res_c = &a_i;
        end
        OP_DEC: begin
          res_y = a_i - WIDTH'(1);
          res_c = ~|a_i;
        end
        default: ;
      endcase
    end
  end

  // Control FSM; y_o and flags are written only on the edge that raises done_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      y_o    <= '0;
      z_o    <= 1'b0;
      c_o    <= 1'b0;
      v_o    <= 1'b0;
      n_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            a_q    <= a_i;
            busy_o <= 1'b1;
            if (is_multi(op_i)) begin
              state <= S_ITER;
              cnt   <= CNT_W'(WIDTH);
            end else begin
              state  <= S_DONE;
              done_o <= 1'b1;
              y_o    <= res_y;
              z_o    <= (res_y == '0);
              c_o    <= res_c;
              v_o    <= res_v;
              n_o    <= res_y[MSB];
            end
          end
        end
        S_ITER: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            y_o    <= res_y;
            z_o    <= (res_y == '0);
            c_o    <= res_c;
            v_o    <= res_v;
            n_o    <= res_y[MSB];
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_alu_seq.md
# cpu_alu_seq

Parametrised, registered ALU: next-generation arithmetic unit for the CPU datapath. Executes the existing single-cycle operation set at configurable width with registered result and flags, and adds carry-chained add/subtract (ADC/SBC) and iterative unsigned multiply, divide and modulo. A start/busy/done handshake lets the control unit stall on multi-cycle operations.

## Interface
- `WIDTH`, 8: operand/result width, ≥ 2.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: request; accepted only when `busy_o`=0.
- `op_i` in 5: opcode. Bit 4=0 means the legacy 4-bit codes from `operations.vh`, unchanged. Extended codes are `OP_ADC`=5'h10, `OP_SBC`=5'h11, `OP_MUL`=5'h12, `OP_DIVU`=5'h13 and `OP_MODU`=5'h14.
- `a_i`, `b_i` in WIDTH: operands, sampled at acceptance.
- `busy_o` out 1: operation in flight.
- `done_o` out 1: one-cycle pulse; `y_o` and the flags are updated in this cycle.
- `y_o` out WIDTH: registered result, held until the next `done_o`.
- `z_o`, `c_o`, `v_o`, `n_o` out 1: registered zero, carry/borrow, overflow and negative flags.

## Operation
- Reset drives state to IDLE and clears `busy_o`, `done_o`, `y_o` and all flags to 0.
- Acceptance happens at a rising edge with `start_i`=1 and state IDLE. The block latches `op_i`, `a_i`, `b_i`, and the current `c_o` as carry-in.
- `start_i` is ignored in ITER and DONE. There is no queuing.
- States:
  - IDLE: single-cycle op goes to DONE. MUL, DIVU or MODU goes to ITER with counter=WIDTH.
  - ITER: one step per cycle, counter decrements; at 1, goes to DONE.
  - DONE: `done_o`=1, then IDLE.
- `busy_o` = (state ≠ IDLE).
- Results and flags, in WIDTH-bit arithmetic:
  - ADD/ADC: a+b(+cin). C = carry out. V = a,b same sign and result sign differs.
  - SUB/SBC: a−b(−cin). C = borrow (1 when the unsigned result underflows). V = a,b differ in sign and result sign differs from a.
  - AND/OR/XOR/PASS_A/MOVE_REG_XA/PASS_B/MOVE_REG_AX: C=0, V=0.
  - SHL: C = a[MSB]. SHR: C = a[0], with 0 shifted into the MSB. V=0.
  - INC: C = (a == all-ones). DEC: C = (a == 0). V=0.
  - MUL: shift-add, y = low WIDTH bits of the product. C = 1 when any high product bit ≠ 0. V=0.
  - DIVU/MODU: restoring division, y = quotient or remainder. With b=0, DIVU gives y=all-ones and C=1; MODU gives y=a and C=1. Otherwise C=0. V=0.
  - Undefined opcode: y=0, C=V=0. Still passes through DONE.
- For all ops: Z = (y==0), N = y[MSB].
- Flags and `y_o` change only in the cycle `done_o`=1.

## Timing
- Single-cycle ops: accepted at edge k; `done_o` is high in cycle k+1 (latency 1). The next start can be accepted at edge k+2.
- MUL/DIVU/MODU: accepted at edge k; `busy_o` is high for cycles k+1..k+WIDTH+1; `done_o` is high in cycle k+WIDTH+1 (latency WIDTH+1).
- `rst_i` mid-operation takes priority over everything. The next cycle is IDLE with all outputs 0, and the in-flight result is discarded. A start on the first edge after reset deasserts is accepted.
- ADC/SBC use the carry flag from the previous completed op. After reset, cin=0.
- Operand changes after acceptance have no effect.

## Structure
- Extend `operations.vh` with `OP_W`=5 and the five extended codes. Legacy codes sit unchanged in the low 4 bits with bit 4=0.
- Sub-module `cpu_alu_muldiv`:
  - holds the shift-add multiplier and restoring divider with their product/remainder registers;
  - driven by the top FSM (`load`, `step`);
  - reports `high_nz` and `div_zero`.
- The top module holds the FSM, counter, single-cycle datapath and flag registers.

## Test plan
- WIDTH=8, ADD 8'h7F+8'h01 → `done_o` one cycle after accept; y=8'h80, V=1, N=1, C=0, Z=0.
- SUB 8'h00−8'h01 → y=8'hFF, C=1, N=1. Then SBC 8'h05−8'h02 → y=8'h02, C=0.
- MUL 8'h10×8'h11 → `done_o` exactly 9 cycles after accept, y=8'h10, C=1. A `start_i` (ADD) pulsed during busy is ignored, and y is unchanged afterwards.
- DIVU 200/7 → y=28, C=0. MODU 200/7 → y=4. DIVU 5/0 → y=8'hFF, C=1.
- Start MUL, assert `rst_i` on cycle 4 → next cycle `busy_o`=0, `done_o`=0, y=0, all flags 0. ADD 3+4 on the following edge → y=7 after one cycle.
- WIDTH=16, ADD 16'hFFFF+16'h0001 → y=0, Z=1, C=1, V=0. Then ADC 0+0 → y=1.
